wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back scheduler between the dual-issue pipeline and the register file.
//  - Accepts up to two write-backs per cycle. Slot 1 is older, slot 2 younger.
//  - Resolves same-cycle WAW between the two slots.
//  - Queues surviving writes in a small 2-in/1-out buffer.
//  - Retires them in program order through a single register-file write port.
//  - Back-pressures issue with wa_o_ready when the buffer cannot take a pair.
// PARAMETERS
//  AWIDTH  `AWIDTH (5)   register address width
//  DWIDTH  `DWIDTH (32)  data width
//  DEPTH   4             buffer entries; power of 2, >= 2
//  CWIDTH  $clog2(DEPTH+1)  occupancy counter width (derived)
// PORTS
//  wa_clk          in   1       clock, rising edge
//  wa_rst          in   1       asynchronous reset, active-high
//  wa_i_wb1_valid  in   1       slot-1 (older) write-back valid
//  wa_i_wb1_addr   in   AWIDTH  slot-1 destination rd
//  wa_i_wb1_data   in   DWIDTH  slot-1 result
//  wa_i_wb2_valid  in   1       slot-2 (younger) write-back valid
//  wa_i_wb2_addr   in   AWIDTH  slot-2 destination rd
//  wa_i_wb2_data   in   DWIDTH  slot-2 result
//  wa_o_ready      out  1       pair accepted this cycle; low = stall issue
//  wa_o_rf_we      out  1       register-file write enable
//  wa_o_rf_addr    out  AWIDTH  register-file write address
//  wa_o_rf_data    out  DWIDTH  register-file write data
//  wa_o_pending    out  1       buffer non-empty
//  wa_i_rs_addr    in   AWIDTH  forwarding lookup address (see CONFIGURATION)
//  wa_o_rs_hit     out  1       lookup hit
//  wa_o_rs_data    out  DWIDTH  lookup data
// BEHAVIOUR
//  Reset (async, wa_rst=1):
//   - count=0, pointers=0, state=EMPTY; all buffered writes are discarded.
//   - wa_o_rf_we=0, rf_addr=0, rf_data=0, pending=0, rs_hit=0, rs_data=0.
//   - wa_o_ready=1.
//  Acceptance:
//   - wa_o_ready = (count <= DEPTH-2), combinational from count.
//   - A slot is taken only when its valid=1 and wa_o_ready=1.
//   - Inputs presented while ready=0 are ignored; the upstream holds them.
//  Filtering, per accepted cycle:
//   - A write with addr==0 is dropped ($zero).
//   - If both slots are valid with equal addr!=0, slot 1 is dropped and only slot 2 enqueues.
//   - Otherwise slot 1 enqueues first, then slot 2, so buffer order is program order.
//  Retire:
//   - Output is the buffer head: rf_we = (count!=0), rf_addr/rf_data = head entry (combinational).
//   - The head pops every cycle count!=0.
//   - Latency: write accepted at edge N is on rf_* during cycle N+1 when the buffer was empty.
//  Counter:
//   - count_next = count + n_enq - pop, with n_enq in {0,1,2} and pop in {0,1}.
//   - Enqueue and dequeue in the same cycle are legal. Pointers wrap modulo DEPTH.
//   - Overflow is impossible by the ready rule; the bench asserts count <= DEPTH.
//  FSM (registered state; status only, drives no datapath):
//   - EMPTY : count==0.
//   - ACTIVE: 0 < count <= DEPTH-2.
//   - FULL  : count > DEPTH-2, which forces ready=0.
//   - The next state is decoded from count_next, so EMPTY->FULL in one cycle is legal.
//   - wa_o_pending = (state != EMPTY).
//  WAW across cycles: both writes stay buffered and retire in order, so the final value is the younger one.
// CONFIGURATION
//  WB_ARB_FWD_EN defined:
//   - wa_o_rs_hit=1 when any valid buffer entry has addr==wa_i_rs_addr!=0.
//   - wa_o_rs_data = data of the youngest matching entry. Combinational, buffer only; same-cycle inputs are not searched.
//  WB_ARB_FWD_EN undefined:
//   - Ports remain. wa_o_rs_hit=0 and wa_o_rs_data=0 constantly.
//   - wa_i_rs_addr is unused.
// STRUCTURE
//  Shared header (header.vh):
//   - `AWIDTH, `DWIDTH.
//   - `WA_ST_EMPTY=2'd0, `WA_ST_ACTIVE=2'd1, `WA_ST_FULL=2'd2.
//   - Entry layout {addr,data} width macro `WA_EWIDTH.
//  One sub-module wb_pair_fifo: 2-push/1-pop buffer.
//   - Owns storage, pointers, count and the forwarding CAM search.
//   - wb_arbiter adds filtering, ready and the FSM.
// TESTING
//  1. Reset with both slots valid -> ready=1, rf_we=0, pending=0.
//     Release reset; wb1=(r3,0x11), wb2=(r4,0x22).
//     -> r3 write in cycle 1, r4 write in cycle 2, then rf_we=0.
//  2. wb1=(r5,0xAA), wb2=(r5,0xBB) in one cycle
//     -> exactly one write, r5=0xBB; r5=0xAA never appears on rf_*.
//  3. wb1=(r0,0x1), wb2=(r7,0x2) -> only the r7 write occurs; the r0 write is dropped.
//  4. Back-to-back pairs to distinct rd every cycle, DEPTH=4:
//     - ready drops when count>2 and state goes FULL.
//     - No write is lost or reordered against a reference queue.
//  5. Assert wa_rst with 3 entries buffered -> rf_we=0 immediately (async); after release no stale write appears.
//  6. With WB_ARB_FWD_EN: buffer r9 twice (0x1 then 0x2), rs_addr=r9 -> hit=1, data=0x2.
//     Without the macro -> hit=0, data=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the write-back arbiter: default widths,
// buffer depth, and the status state encoding with its decoder.
package wb_arbiter_pkg;

    localparam int WA_AWIDTH = 5;
    localparam int WA_DWIDTH = 32;
    localparam int WA_DEPTH  = 4;

    typedef enum logic [1:0] {
        WA_ST_EMPTY  = 2'd0,
        WA_ST_ACTIVE = 2'd1,
        WA_ST_FULL   = 2'd2
    } wa_state_e;

    // FULL means the buffer can no longer take a whole pair.
    function automatic wa_state_e wa_decode_state(input int count, input int depth);
        if (count == 0) begin
            return WA_ST_EMPTY;
        end else if (count <= depth - 2) begin
            return WA_ST_ACTIVE;
        end else begin
            return WA_ST_FULL;
        end
    endfunction

endpackage

// File: rtl/wb_pair_fifo.sv
// Two-push / one-pop write-back buffer with occupancy count and an optional
// forwarding search (enabled by WB_ARB_FWD_EN).
module wb_pair_fifo #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        n_enq_i,
    input  logic [AWIDTH-1:0] enq0_addr_i,
    input  logic [DWIDTH-1:0] enq0_data_i,
    input  logic [AWIDTH-1:0] enq1_addr_i,
    input  logic [DWIDTH-1:0] enq1_data_i,
    input  logic              pop_i,
    input  logic [AWIDTH-1:0] rs_addr_i,
    output logic [CWIDTH-1:0] count_o,
    output logic [CWIDTH-1:0] count_next_o,
    output logic [AWIDTH-1:0] head_addr_o,
    output logic [DWIDTH-1:0] head_data_o,
    output logic              rs_hit_o,
    output logic [DWIDTH-1:0] rs_data_o
);

    localparam int PWIDTH = $clog2(DEPTH);

    logic [AWIDTH-1:0] addr_q [DEPTH];
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CWIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q + CWIDTH'(n_enq_i) - CWIDTH'(pop_i);
        wr_ptr_d = wr_ptr_q + PWIDTH'(n_enq_i);
        rd_ptr_d = rd_ptr_q + PWIDTH'(pop_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (n_enq_i != 2'd0) begin
            addr_q[wr_ptr_q] <= enq0_addr_i;
            data_q[wr_ptr_q] <= enq0_data_i;
        end
        if (n_enq_i == 2'd2) begin
            addr_q[wr_ptr_q + PWIDTH'(1)] <= enq1_addr_i;
            data_q[wr_ptr_q + PWIDTH'(1)] <= enq1_data_i;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];

`ifdef WB_ARB_FWD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        rs_hit_o  = 1'b0;
        rs_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CWIDTH'(i) < count_q) && (rs_addr_i != '0) &&
                (addr_q[rd_ptr_q + PWIDTH'(i)] == rs_addr_i)) begin
                rs_hit_o  = 1'b1;
                rs_data_o = data_q[rd_ptr_q + PWIDTH'(i)];
            end
        end
    end
`else
    logic unused_rs_addr;
    assign unused_rs_addr = ^rs_addr_i;
    assign rs_hit_o       = 1'b0;
    assign rs_data_o      = '0;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Write-back scheduler: filters a dual-issue write-back pair, queues it in
// program order and retires one write per cycle. Forwarding: WB_ARB_FWD_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = WA_AWIDTH,
    parameter int DWIDTH = WA_DWIDTH,
    parameter int DEPTH  = WA_DEPTH,
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              wa_clk,
    input  logic              wa_rst,
    input  logic              wa_i_wb1_valid,
    input  logic [AWIDTH-1:0] wa_i_wb1_addr,
    input  logic [DWIDTH-1:0] wa_i_wb1_data,
    input  logic              wa_i_wb2_valid,
    input  logic [AWIDTH-1:0] wa_i_wb2_addr,
    input  logic [DWIDTH-1:0] wa_i_wb2_data,
    output logic              wa_o_ready,
    output logic              wa_o_rf_we,
    output logic [AWIDTH-1:0] wa_o_rf_addr,
    output logic [DWIDTH-1:0] wa_o_rf_data,
    output logic              wa_o_pending,
    input  logic [AWIDTH-1:0] wa_i_rs_addr,
    output logic              wa_o_rs_hit,
    output logic [DWIDTH-1:0] wa_o_rs_data
);

    logic [CWIDTH-1:0] fifo_count;
    logic [CWIDTH-1:0] fifo_count_next;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_data;
    logic              slot1_ok, slot2_ok, pop;
    logic [1:0]        n_enq;
    logic [AWIDTH-1:0] enq0_addr, enq1_addr;
    logic [DWIDTH-1:0] enq0_data, enq1_data;
    wa_state_e         state_q;

    assign wa_o_ready = (fifo_count <= CWIDTH'(DEPTH - 2));

    // Same-rd pair: the older slot is dead on arrival.
    always_comb begin
        slot2_ok = wa_i_wb2_valid && wa_o_ready && (wa_i_wb2_addr != '0);
        slot1_ok = wa_i_wb1_valid && wa_o_ready && (wa_i_wb1_addr != '0) &&
                   !(wa_i_wb2_valid && (wa_i_wb2_addr == wa_i_wb1_addr));
    end

    always_comb begin
        n_enq     = 2'd0;
        enq0_addr = wa_i_wb1_addr;
        enq0_data = wa_i_wb1_data;
        enq1_addr = wa_i_wb2_addr;
        enq1_data = wa_i_wb2_data;
        if (slot1_ok) begin
            n_enq = slot2_ok ? 2'd2 : 2'd1;
        end else if (slot2_ok) begin
            n_enq     = 2'd1;
            enq0_addr = wa_i_wb2_addr;
            enq0_data = wa_i_wb2_data;
        end
    end

    assign pop = (fifo_count != '0);

    wb_pair_fifo #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .CWIDTH (CWIDTH)
    ) u_fifo (
        .clk_i        (wa_clk),
        .rst_i        (wa_rst),
        .n_enq_i      (n_enq),
        .enq0_addr_i  (enq0_addr),
        .enq0_data_i  (enq0_data),
        .enq1_addr_i  (enq1_addr),
        .enq1_data_i  (enq1_data),
        .pop_i        (pop),
        .rs_addr_i    (wa_i_rs_addr),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .rs_hit_o     (wa_o_rs_hit),
        .rs_data_o    (wa_o_rs_data)
    );

    assign wa_o_rf_we   = pop;
    assign wa_o_rf_addr = pop ? head_addr : '0;
    assign wa_o_rf_data = pop ? head_data : '0;

    // Status only; decoding from the next count lets EMPTY jump to FULL.
    always_ff @(posedge wa_clk or posedge wa_rst) begin
        if (wa_rst) begin
            state_q <= WA_ST_EMPTY;
        end else begin
            state_q <= wa_decode_state(int'(fifo_count_next), DEPTH);
        end
    end

    assign wa_o_pending = (state_q != WA_ST_EMPTY);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          wa_clk = 1'b0;
    logic          wa_rst = 1'b0;
    logic          wa_i_wb1_valid = 1'b0;
    logic [AW-1:0] wa_i_wb1_addr = '0;
    logic [DW-1:0] wa_i_wb1_data = '0;
    logic          wa_i_wb2_valid = 1'b0;
    logic [AW-1:0] wa_i_wb2_addr = '0;
    logic [DW-1:0] wa_i_wb2_data = '0;
    logic          wa_o_ready;
    logic          wa_o_rf_we;
    logic [AW-1:0] wa_o_rf_addr;
    logic [DW-1:0] wa_o_rf_data;
    logic          wa_o_pending;
    logic [AW-1:0] wa_i_rs_addr = '0;
    logic          wa_o_rs_hit;
    logic [DW-1:0] wa_o_rs_data;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t mq[$];

    wb_arbiter dut (
        .wa_clk         (wa_clk),
        .wa_rst         (wa_rst),
        .wa_i_wb1_valid (wa_i_wb1_valid),
        .wa_i_wb1_addr  (wa_i_wb1_addr),
        .wa_i_wb1_data  (wa_i_wb1_data),
        .wa_i_wb2_valid (wa_i_wb2_valid),
        .wa_i_wb2_addr  (wa_i_wb2_addr),
        .wa_i_wb2_data  (wa_i_wb2_data),
        .wa_o_ready     (wa_o_ready),
        .wa_o_rf_we     (wa_o_rf_we),
        .wa_o_rf_addr   (wa_o_rf_addr),
        .wa_o_rf_data   (wa_o_rf_data),
        .wa_o_pending   (wa_o_pending),
        .wa_i_rs_addr   (wa_i_rs_addr),
        .wa_o_rs_hit    (wa_o_rs_hit),
        .wa_o_rs_data   (wa_o_rs_data)
    );

    always #5 wa_clk = ~wa_clk;

    task automatic set_in(input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input bit v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        wa_i_wb1_valid = v1; wa_i_wb1_addr = a1; wa_i_wb1_data = d1;
        wa_i_wb2_valid = v2; wa_i_wb2_addr = a2; wa_i_wb2_data = d2;
    endtask

    // Reference: one retire per cycle from the front; a pair is taken only
    // while at most DEPTH-2 writes are waiting, with $zero and WAW filtering.
    task automatic model_step();
        bit rdy;
        rdy = (mq.size() <= DEPTH - 2);
        if (mq.size() > 0) void'(mq.pop_front());
        if (rdy) begin
            if (wa_i_wb1_valid && wa_i_wb1_addr != 0 &&
                !(wa_i_wb2_valid && wa_i_wb2_addr == wa_i_wb1_addr))
                mq.push_back('{wa_i_wb1_addr, wa_i_wb1_data});
            if (wa_i_wb2_valid && wa_i_wb2_addr != 0)
                mq.push_back('{wa_i_wb2_addr, wa_i_wb2_data});
        end
        @(posedge wa_clk);
        @(negedge wa_clk);
    endtask

    function automatic logic [DW:0] fwd_ref(input logic [AW-1:0] rs);
        logic [DW:0] r;
        r = '0;
`ifdef WB_ARB_FWD_EN
        if (rs != 0)
            foreach (mq[i]) if (mq[i].addr == rs) r = {1'b1, mq[i].data};
`else
        r[0] = r[0] & (^rs);
`endif
        return r;
    endfunction

    task automatic drain();
        set_in(0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 20 && mq.size() > 0; i++) model_step();
        n_cmp++;
        if (mq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: model still holds %0d entries, required 0", mq.size());
        end
        model_step();
    endtask

    task automatic test_reset();
        wa_rst = 1'b1;
        set_in(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        @(negedge wa_clk); #1;
        n_cmp++; if (wa_o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wa_o_ready); end
        n_cmp++; if (wa_o_rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", wa_o_rf_we); end
        n_cmp++; if (wa_o_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", wa_o_pending); end
        n_cmp++; if ({wa_o_rf_addr, wa_o_rf_data, wa_o_rs_hit, wa_o_rs_data} !== '0) begin
            n_fail++; $display("FAIL reset_outs: rf_addr=%0d rf_data=%h rs_hit=%b rs_data=%h want all 0",
                               wa_o_rf_addr, wa_o_rf_data, wa_o_rs_hit, wa_o_rs_data);
        end
        wa_rst = 1'b0;
        mq.delete();
        model_step();
        set_in(0, '0, '0, 0, '0, '0);
        #1;
        n_cmp++; if ({wa_o_rf_we, wa_o_rf_addr, wa_o_rf_data} !== {1'b1, 5'd3, 32'h11}) begin
            n_fail++; $display("FAIL first_write: got we=%b r%0d=%h want we=1 r3=11", wa_o_rf_we, wa_o_rf_addr, wa_o_rf_data);
        end
        model_step(); #1;
        n_cmp++; if ({wa_o_rf_we, wa_o_rf_addr, wa_o_rf_data} !== {1'b1, 5'd4, 32'h22}) begin
            n_fail++; $display("FAIL second_write: got we=%b r%0d=%h want we=1 r4=22", wa_o_rf_we, wa_o_rf_addr, wa_o_rf_data);
        end
        model_step(); #1;
        n_cmp++; if (wa_o_rf_we !== 1'b0) begin n_fail++; $display("FAIL after_pair_we: got %b want 0", wa_o_rf_we); end
    endtask

    task automatic test_waw();
        int n5, nall;
        bit saw_aa;
        logic [DW-1:0] d5;
        n5 = 0; nall = 0; saw_aa = 0; d5 = '0;
        set_in(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
        model_step();
        set_in(0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (wa_o_rf_we) begin
                nall++;
                if (wa_o_rf_addr == 5'd5) begin n5++; d5 = wa_o_rf_data; end
                if (wa_o_rf_data == 32'hAA) saw_aa = 1;
            end
            model_step();
        end
        n_cmp++; if (nall != 1 || n5 != 1) begin n_fail++; $display("FAIL waw_count: got %0d writes (%0d to r5) want 1", nall, n5); end
        n_cmp++; if (d5 !== 32'hBB) begin n_fail++; $display("FAIL waw_data: got %h want bb", d5); end
        n_cmp++; if (saw_aa) begin n_fail++; $display("FAIL waw_stale: older value aa reached rf, want never"); end
    endtask

    task automatic test_zero();
        int nall;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        nall = 0; a = '0; d = '0;
        set_in(1, 5'd0, 32'h1, 1, 5'd7, 32'h2);
        model_step();
        set_in(0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (wa_o_rf_we) begin nall++; a = wa_o_rf_addr; d = wa_o_rf_data; end
            model_step();
        end
        n_cmp++; if (nall != 1 || a !== 5'd7 || d !== 32'h2) begin
            n_fail++; $display("FAIL zero_drop: got %0d writes last r%0d=%h want 1 write r7=2", nall, a, d);
        end
    endtask

    // Back-to-back or random traffic; upstream holds a pair until accepted.
    task automatic test_traffic(input bit distinct, input int ncyc, input string tag);
        bit acc, saw_full;
        ent_t e;
        logic [DW:0] f;
        wa_state_e st;
        acc = 1; saw_full = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (acc) begin
                if (distinct) begin
                    logic [AW-1:0] a;
                    a = AW'($urandom_range(1, 15));
                    set_in(1, a, $urandom, 1, a + AW'(16), $urandom);
                end else begin
                    set_in(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom,
                           ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom);
                end
            end
            wa_i_rs_addr = AW'($urandom_range(0, 7));
            #1;
            e  = (mq.size() > 0) ? mq[0] : '0;
            f  = fwd_ref(wa_i_rs_addr);
            st = (mq.size() == 0) ? WA_ST_EMPTY : (mq.size() <= DEPTH - 2) ? WA_ST_ACTIVE : WA_ST_FULL;
            if (st == WA_ST_FULL) saw_full = 1;
            n_cmp++; if (wa_o_ready !== (mq.size() <= DEPTH - 2)) begin
                n_fail++; $display("FAIL %s_ready c%0d: got %b want %b", tag, c, wa_o_ready, mq.size() <= DEPTH - 2);
            end
            n_cmp++; if ({wa_o_rf_we, wa_o_rf_addr, wa_o_rf_data} !== {mq.size() > 0, e.addr, e.data}) begin
                n_fail++; $display("FAIL %s_rf c%0d: got we=%b r%0d=%h want we=%b r%0d=%h", tag, c,
                                   wa_o_rf_we, wa_o_rf_addr, wa_o_rf_data, mq.size() > 0, e.addr, e.data);
            end
            n_cmp++; if (wa_o_pending !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL %s_pending c%0d: got %b want %b", tag, c, wa_o_pending, mq.size() > 0);
            end
            n_cmp++; if (dut.state_q !== st) begin
                n_fail++; $display("FAIL %s_state c%0d: got %0d want %0d", tag, c, dut.state_q, st);
            end
            n_cmp++; if (dut.u_fifo.count_o > 3'(DEPTH)) begin
                n_fail++; $display("FAIL %s_bound c%0d: count %0d exceeds %0d", tag, c, dut.u_fifo.count_o, DEPTH);
            end
            n_cmp++; if ({wa_o_rs_hit, wa_o_rs_data} !== f) begin
                n_fail++; $display("FAIL %s_fwd c%0d: got hit=%b data=%h want hit=%b data=%h", tag, c,
                                   wa_o_rs_hit, wa_o_rs_data, f[DW], f[DW-1:0]);
            end
            acc = (mq.size() <= DEPTH - 2);
            model_step();
        end
        if (distinct) begin
            n_cmp++; if (!saw_full) begin n_fail++; $display("FAIL %s_full: FULL state never reached, want reached", tag); end
        end
        wa_i_rs_addr = '0;
        drain();
    endtask

    task automatic test_async_reset();
        set_in(1, 5'd1, 32'h100, 1, 5'd2, 32'h200);
        model_step();
        set_in(1, 5'd3, 32'h300, 1, 5'd4, 32'h400);
        model_step();
        set_in(0, '0, '0, 0, '0, '0);
        n_cmp++; if (mq.size() != 3 || wa_o_rf_we !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: got we=%b model %0d entries want we=1 with 3", wa_o_rf_we, mq.size());
        end
        #2 wa_rst = 1'b1;
        #1;
        mq.delete();
        n_cmp++; if ({wa_o_rf_we, wa_o_pending, wa_o_ready} !== 3'b001) begin
            n_fail++; $display("FAIL arst_now: got we=%b pending=%b ready=%b want 0 0 1", wa_o_rf_we, wa_o_pending, wa_o_ready);
        end
        @(negedge wa_clk);
        wa_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (wa_o_rf_we !== 1'b0) begin
                n_fail++; $display("FAIL arst_stale c%0d: got we=1 r%0d=%h want no write", i, wa_o_rf_addr, wa_o_rf_data);
            end
            model_step();
        end
    endtask

    task automatic test_forward();
        logic [DW:0] want;
`ifdef WB_ARB_FWD_EN
        want = {1'b1, 32'h2};
`else
        want = '0;
`endif
        set_in(1, 5'd1, 32'h55, 1, 5'd9, 32'h1);
        model_step();
        set_in(1, 5'd9, 32'h2, 0, '0, '0);
        model_step();
        set_in(0, '0, '0, 0, '0, '0);
        wa_i_rs_addr = 5'd9;
        #1;
        n_cmp++; if ({wa_o_rs_hit, wa_o_rs_data} !== want) begin
            n_fail++; $display("FAIL fwd_r9: got hit=%b data=%h want hit=%b data=%h",
                               wa_o_rs_hit, wa_o_rs_data, want[DW], want[DW-1:0]);
        end
        wa_i_rs_addr = 5'd0;
        #1;
        n_cmp++; if (wa_o_rs_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_r0: got hit=%b want 0", wa_o_rs_hit); end
        drain();
    endtask

    initial begin
        #1 wa_rst = 1'b1;
        test_reset();
        test_waw();
        test_zero();
        test_traffic(1'b1, 40, "b2b");
        test_traffic(1'b0, 300, "rand");
        test_async_reset();
        test_forward();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
